// File: rtl/mips_pkg.sv
// mips_pkg: shared register width and hazard FSM state encoding
package mips_pkg;
    localparam int NB_REG_ADDR = 5;
    typedef enum logic {ST_IDLE, ST_STALL} hdu_state_t;
endpackage

// File: rtl/hazard_match.sv
// hazard_match: one source-vs-destination compare with r0 exclusion and use gating
module hazard_match
    import mips_pkg::*;
#(
    parameter int NB_REG_ADDR = mips_pkg::NB_REG_ADDR
) (
    input  logic [NB_REG_ADDR-1:0] i_src,
    input  logic [NB_REG_ADDR-1:0] i_rd,
    input  logic                   i_we,
    input  logic                   i_use,
    output logic                   o_match
);
    assign o_match = i_use & i_we & (|i_rd) & (i_src == i_rd);
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: decode-stage stall/bubble/flush control with saturating stall counter
module hazard_detection_unit
    import mips_pkg::*;
#(
    parameter int NB_REG_ADDR = mips_pkg::NB_REG_ADDR,
    parameter int NB_CNT      = 16
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic [NB_REG_ADDR-1:0] i_rs_id,
    input  logic [NB_REG_ADDR-1:0] i_rt_id,
    input  logic                   i_use_rs,
    input  logic                   i_use_rt,
    input  logic                   i_branch_id,
    input  logic                   i_jump_rs_id,
    input  logic [NB_REG_ADDR-1:0] i_rd_ex,
    input  logic                   i_we_ex,
    input  logic                   i_memread_ex,
    input  logic [NB_REG_ADDR-1:0] i_rd_mem,
    input  logic                   i_memread_mem,
    input  logic                   i_taken,
    output logic                   o_stall_pc,
    output logic                   o_stall_ifid,
    output logic                   o_bubble_idex,
    output logic                   o_flush_ifid,
    output logic [NB_CNT-1:0]      o_stall_cnt
);
    hdu_state_t        state_q, state_d;
    logic [1:0]        rem_q, rem_d, n;
    logic [NB_CNT-1:0] cnt_q, cnt_d;
    logic              ctl, use_rt, m_rs_ex, m_rt_ex, m_rs_mem, m_rt_mem, m_ex, m_mem, stall;

    assign ctl    = i_branch_id | i_jump_rs_id;
    assign use_rt = i_use_rt & ~i_jump_rs_id;

    hazard_match #(.NB_REG_ADDR(NB_REG_ADDR)) u_rs_ex (
        .i_src(i_rs_id), .i_rd(i_rd_ex), .i_we(i_we_ex), .i_use(i_use_rs), .o_match(m_rs_ex)
    );
    hazard_match #(.NB_REG_ADDR(NB_REG_ADDR)) u_rt_ex (
        .i_src(i_rt_id), .i_rd(i_rd_ex), .i_we(i_we_ex), .i_use(use_rt), .o_match(m_rt_ex)
    );
    hazard_match #(.NB_REG_ADDR(NB_REG_ADDR)) u_rs_mem (
        .i_src(i_rs_id), .i_rd(i_rd_mem), .i_we(i_memread_mem), .i_use(i_use_rs), .o_match(m_rs_mem)
    );
    hazard_match #(.NB_REG_ADDR(NB_REG_ADDR)) u_rt_mem (
        .i_src(i_rt_id), .i_rd(i_rd_mem), .i_we(i_memread_mem), .i_use(use_rt), .o_match(m_rt_mem)
    );

    assign m_ex  = m_rs_ex | m_rt_ex;
    assign m_mem = m_rs_mem | m_rt_mem;

    always_comb begin
        n       = (state_q != ST_IDLE)          ? 2'd0 :
                  (ctl & m_ex & i_memread_ex)   ? 2'd2 :
                  (ctl & (m_ex | m_mem))        ? 2'd1 :
                  (m_ex & i_memread_ex)         ? 2'd1 : 2'd0;
        stall   = (state_q == ST_STALL) | (n != 2'd0);
        state_d = (state_q == ST_STALL) ? ((rem_q == 2'd1) ? ST_IDLE : ST_STALL) :
                  ((n == 2'd2) ? ST_STALL : ST_IDLE);
        rem_d   = (state_q == ST_STALL) ? rem_q - 2'd1 : ((n == 2'd2) ? 2'd1 : 2'd0);
        cnt_d   = (stall & ~&cnt_q) ? cnt_q + {{(NB_CNT-1){1'b0}}, 1'b1} : cnt_q;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            rem_q   <= 2'd0;
            cnt_q   <= '0;
        end else if (i_valid) begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_stall_pc    = stall;
    assign o_stall_ifid  = stall;
    assign o_bubble_idex = stall;
    assign o_flush_ifid  = i_taken & ~stall;
    assign o_stall_cnt   = cnt_q;
endmodule

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Decode-stage hazard controller for the 5-stage MIPS pipeline, placed beside the forwarding unit that supplies EX and branch-compare operands. It detects dependences that forwarding cannot cover (load-use, and branch/jr operands produced in EX or by a load), then stalls PC and IF/ID while injecting bubbles into ID/EX for the required number of cycles. It also flushes IF/ID on a taken branch or jump and keeps a saturating count of stall cycles for debug.

## Interface
- NB_REG_ADDR, 5, register address width
- NB_CNT, 16, stall-cycle counter width
- i_clock  in  1  clock
- i_reset  in  1  synchronous, active-high reset; clock i_clock
- i_valid  in  1  pipeline advance enable; FSM and counter frozen when 0
- i_rs_id  in  NB_REG_ADDR  rs of instruction in ID
- i_rt_id  in  NB_REG_ADDR  rt of instruction in ID
- i_use_rs  in  1  ID instruction reads rs
- i_use_rt  in  1  ID instruction reads rt
- i_branch_id  in  1  ID holds beq/bne (compares rs, rt in ID)
- i_jump_rs_id  in  1  ID holds jr/jalr (reads rs in ID)
- i_rd_ex  in  NB_REG_ADDR  destination in EX
- i_we_ex  in  1  EX writes register
- i_memread_ex  in  1  EX is a load
- i_rd_mem  in  NB_REG_ADDR  destination in MEM
- i_memread_mem  in  1  MEM is a load
- i_taken  in  1  branch/jump in ID resolved taken
- o_stall_pc  out  1  hold PC
- o_stall_ifid  out  1  hold IF/ID
- o_bubble_idex  out  1  load NOP into ID/EX
- o_flush_ifid  out  1  clear IF/ID
- o_stall_cnt  out  NB_CNT  saturating count of stall cycles

## Operation
- Match rule: mX_ex = (src==i_rd_ex)&i_we_ex&(i_rd_ex!=0)&use; mX_mem = (src==i_rd_mem)&i_memread_mem&(i_rd_mem!=0)&use. Register 0 never hazards.
- Required stall count N, evaluated in IDLE only, ctl = i_branch_id|i_jump_rs_id; for jr only rs counts:
  - ctl & match_ex & i_memread_ex -> N=2
  - ctl & match_ex & ~i_memread_ex -> N=1
  - ctl & match_mem (load in MEM) -> N=1
  - ~ctl & match_ex & i_memread_ex -> N=1 (load-use)
  - otherwise N=0
  - Priority: first matching row wins.
- FSM: IDLE, STALL.
  - IDLE, N>0: stall outputs asserted this cycle. N=2 -> STALL with rem=1. N=1 -> remain IDLE (re-evaluates next cycle on advanced pipeline).
  - STALL: stall outputs asserted; rem decrements; rem reaching 0 -> IDLE. No re-evaluation in STALL.
- stall = (IDLE & N>0) | STALL. o_stall_pc = o_stall_ifid = o_bubble_idex = stall.
- o_flush_ifid = i_taken & ~stall. A taken resolution seen during a stall is ignored; ID re-presents it after the stall.
- o_stall_cnt increments on each cycle with stall & i_valid and saturates at 2^NB_CNT-1.
- i_valid=0: state, rem, and counter hold. Outputs are still driven from current state and inputs.

## Timing
- Stall and flush outputs are combinational from inputs and state, with the same-cycle effect required by the PC and IF/ID enables.
- State, rem, and o_stall_cnt are registered and update on the i_clock rising edge when i_valid=1.
- Reset: state=IDLE, rem=0, o_stall_cnt=0. With inputs quiet, all outputs are 0.
- Reset mid-STALL: next cycle is IDLE, and the remaining stall is abandoned. The pipeline registers are reset by the same signal.
- Load-use: exactly 1 bubble. Branch on ALU result in EX: 1. Branch on load in EX: 2, consecutive. Branch on load in MEM: 1.
- Simultaneous i_taken with N>0: stall wins, and flush is 0.

## Structure
- Shared package mips_pkg holds the FSM state localparams (ST_IDLE, ST_STALL) and NB_REG_ADDR.
- Sub-module hazard_match does the per-source compare, including the r0 exclusion and use gating. It is instantiated four times: rs and rt, each against EX and MEM.
- The top level holds the N decode, FSM, rem, and counter. Target size is about 150–200 lines.

## Test plan
- Load r5 in EX (i_memread_ex=1, i_rd_ex=5); ID add uses rs=5 -> stall=1 for exactly 1 cycle, then 0 once the load moves to MEM; o_stall_cnt=1.
- beq rs=3 with load rd=3 in EX -> stall=1 for 2 consecutive cycles (IDLE→STALL→IDLE), then o_flush_ifid=i_taken; o_stall_cnt=2.
- jr rs=7 with ALU rd=7 in EX (i_memread_ex=0) -> 1 stall cycle. Same case with rt match only, not rs -> 0 stalls.
- i_rd_ex=0, i_we_ex=1, i_memread_ex=1, ID uses rs=0 -> no stall. i_taken=1 during any stall -> o_flush_ifid=0.
- Reset asserted in STALL -> next cycle state IDLE, outputs 0, o_stall_cnt=0. With i_valid=0 during a 2-cycle stall, stall stays asserted and rem and the counter hold until i_valid returns.
- With NB_CNT=2, force 5 stall cycles -> o_stall_cnt saturates at 3.
